serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing a_in - b_in, LSB first, one bit per clock.
- Uses a registered borrow and a 1-bit full_subtractor cell.
- It is the inverse-operation companion to the team's adder cells, used in the arithmetic labs where area matters more than latency.
- A start/busy/done handshake lets a controlling FSM or testbench launch operations.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
// Optional feature macro used by the design: SERIAL_SUB_OVF_EN (adds ovf_out).
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  // Default operand/result width in bits.
  localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

  // Controller states. Encodings are fixed so other tools and labs can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purely combinational 1-bit full subtractor cell: computes a - b - bin.
// Ports:
//   a_in     : minuend bit
//   b_in     : subtrahend bit
//   bin_in   : borrow in
//   diff_out : difference bit (a ^ b ^ bin)
//   bout_out : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a_in,
  input  logic b_in,
  input  logic bin_in,
  output logic diff_out,
  output logic bout_out
);

  assign diff_out = a_in ^ b_in ^ bin_in;
  // Borrow out when the subtrahend side (b plus incoming borrow) exceeds a.
  assign bout_out = (~a_in & b_in) | (~a_in & bin_in) | (b_in & bin_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit unsigned subtractor (a_in - b_in, modulo 2^WIDTH),
// processed LSB first, one bit per clock, through a single full_subtractor
// cell and a registered borrow. A start/busy/done handshake launches work.
//
// Parameters:
//   WIDTH      : operand/result width (>= 2)
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   start_in   : start request, only honoured in IDLE or DONE
//   a_in/b_in  : minuend / subtrahend, captured on an accepted start
//   busy_out   : high while the FSM is in SHIFT
//   done_out   : one-cycle pulse while in DONE (result valid)
//   diff_out   : difference, held until the next completion or reset
//   borrow_out : final borrow (a_in < b_in unsigned), held with diff_out
//   ovf_out    : signed overflow flag, present only when SERIAL_SUB_OVF_EN
//                is defined
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fs_diff;
  logic fs_bout;

  full_subtractor u_fs (
    .a_in     (a_q[0]),
    .b_in     (b_q[0]),
    .bin_in   (borrow_q),
    .diff_out (fs_diff),
    .bout_out (fs_bout)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d        = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = 1'b0;
          count_d  = '0;
          res_d    = '0;
          state_d  = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        // New difference bit enters at the MSB; after WIDTH shifts the
        // first (LSB) bit has walked down to bit 0.
        res_d    = {fs_diff, res_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          diff_d       = {fs_diff, res_q[WIDTH-1:1]};
          borrow_out_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the MSB differs from borrow out of it.
          ovf_d        = borrow_q ^ fs_bout;
`endif
          state_d      = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  // Handshake outputs are straight decodes of the registered state.
  assign busy_out   = (state_q == ST_SHIFT);
  assign done_out   = (state_q == ST_DONE);
  assign diff_out   = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_out    = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed self-checking bench for serial_subtractor (WIDTH=8). Expected
// results are pushed to a scoreboard queue at each accepted start and popped
// when done_out is observed. Define SERIAL_SUB_OVF_EN to cover ovf_out.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start_in = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_out;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive a start for one edge; optionally record the expected result.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit track);
    exp_t e;
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    if (track) sb_q.push_back(e);
    step();
    start_in = 1'b0;
    chk("busy_after_start", {31'd0, busy_out}, 32'd1);
    chk("no_done_after_start", {31'd0, done_out}, 32'd0);
  endtask

  // Wait (bounded) for done_out, check latency and the result against the scoreboard.
  task automatic wait_done(input string tag, input int exp_cycles);
    int   n;
    exp_t e;
    n = 0;
    while (done_out !== 1'b1 && n < 4 * WIDTH) begin
      chk({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_cycles);
    chk({tag, "_done"}, {31'd0, done_out}, 32'd1);
    chk({tag, "_busy_in_done"}, {31'd0, busy_out}, 32'd0);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_diff"}, {24'd0, diff_out}, {24'd0, e.diff});
      chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, e.borrow});
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf_out}, {31'd0, e.ovf});
`endif
      $display("txn %s: diff=0x%02h borrow=%0d (exp 0x%02h/%0d) cycles=%0d",
               tag, diff_out, borrow_out, e.diff, e.borrow, n);
    end
  endtask

  initial begin
    // 1. Reset for two cycles, then idle.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_diff", {24'd0, diff_out}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf_out}, 32'd0);
`endif
    $display("txn reset: busy=%0d done=%0d diff=0x%02h", busy_out, done_out, diff_out);

    // 2. Basic subtraction.
    start_op(8'h5A, 8'h23, 1'b1);
    wait_done("t2_5a_23", WIDTH);
    step();
    chk("t2_done_pulse_end", {31'd0, done_out}, 32'd0);
    chk("t2_diff_held", {24'd0, diff_out}, 32'h37);

    // 3. Underflow, then equal operands.
    start_op(8'h10, 8'h20, 1'b1);
    wait_done("t3_10_20", WIDTH);
    step();
    start_op(8'h00, 8'h00, 1'b1);
    wait_done("t3_00_00", WIDTH);
    step();

    // 4. Start while busy is ignored; start in DONE is accepted back-to-back.
    start_op(8'hFF, 8'h01, 1'b1);
    step();
    a_in     = 8'h00;
    b_in     = 8'h01;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_done("t4_ff_01", WIDTH - 2);
    start_op(8'h00, 8'h01, 1'b1);
    wait_done("t4_b2b_00_01", WIDTH);
    step();
    chk("t4_idle_after", {31'd0, done_out}, 32'd0);

    // 5. Reset mid-operation discards the partial result.
    start_op(8'h40, 8'h01, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", {31'd0, busy_out}, 32'd0);
    chk("t5_done", {31'd0, done_out}, 32'd0);
    chk("t5_diff", {24'd0, diff_out}, 32'd0);
    chk("t5_borrow", {31'd0, borrow_out}, 32'd0);
    for (int i = 0; i < WIDTH + 3; i++) begin
      step();
      chk("t5_no_done", {31'd0, done_out}, 32'd0);
    end
    chk("t5_sb_empty", sb_q.size(), 32'd0);
    $display("txn reset_mid_op: busy=%0d diff=0x%02h", busy_out, diff_out);

`ifdef SERIAL_SUB_OVF_EN
    // 6. Signed overflow flag.
    start_op(8'h80, 8'h01, 1'b1);
    wait_done("t6_80_01", WIDTH);
    chk("t6_ovf_set", {31'd0, ovf_out}, 32'd1);
    step();
    start_op(8'h05, 8'h03, 1'b1);
    wait_done("t6_05_03", WIDTH);
    chk("t6_ovf_clr", {31'd0, ovf_out}, 32'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor
